// File: rtl/chk_gnot16_if.sv
// Stimulus/response bundle between a NOT-gate tester and the chk_gnot16 monitor.
// master: side that drives run control and a/y pairs; slave: the monitor.
interface chk_gnot16_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] n_samples;
    logic [CNT_W-1:0] n_errors;
    logic [WIDTH-1:0] bad_a;
    logic [WIDTH-1:0] bad_y;

    modport master (
        output start, len, valid, a, y,
        input  busy, done, pass, n_samples, n_errors, bad_a, bad_y
    );

    modport slave (
        input  start, len, valid, a, y,
        output busy, done, pass, n_samples, n_errors, bad_a, bad_y
    );
endinterface

// File: rtl/chk_gnot16.sv
// Self-checking response monitor for a 16-bit NOT gate: checks y == ~a on
// each valid pair of a run, counts samples/mismatches, captures first failure.
// Optional: define CHK_GNOT16_ABORT_EN to end a run on its first mismatch.
module chk_gnot16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    chk_gnot16_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] n_samples_q, n_samples_d;
    logic [CNT_W-1:0] n_errors_q, n_errors_d;
    logic [WIDTH-1:0] bad_a_q, bad_a_d;
    logic [WIDTH-1:0] bad_y_q, bad_y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.n_samples = n_samples_q;
    assign bus.n_errors  = n_errors_q;
    assign bus.bad_a     = bad_a_q;
    assign bus.bad_y     = bad_y_q;

    // Next-state: run control, sample counting, mismatch capture; status flags
    // are derived from the next state so they are registered with it.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        n_samples_d = n_samples_q;
        n_errors_d  = n_errors_q;
        bad_a_d     = bad_a_q;
        bad_y_d     = bad_y_q;
        mismatch    = (bus.y != ~bus.a);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    len_d       = bus.len;
                    n_samples_d = '0;
                    n_errors_d  = '0;
                    bad_a_d     = '0;
                    bad_y_d     = '0;
                    state_d     = (bus.len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.valid) begin
                    n_samples_d = n_samples_q + CNT_W'(1);
                    if (mismatch) begin
                        if (n_errors_q != '1) begin
                            n_errors_d = n_errors_q + CNT_W'(1);
                        end
                        if (n_errors_q == '0) begin
                            bad_a_d = bus.a;
                            bad_y_d = bus.y;
                        end
                    end
                    if (n_samples_d == len_q) begin
                        state_d = S_DONE;
                    end
`ifdef CHK_GNOT16_ABORT_EN
                    if (mismatch && (n_errors_q == '0)) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (n_errors_d == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            n_samples_q <= '0;
            n_errors_q  <= '0;
            bad_a_q     <= '0;
            bad_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            n_samples_q <= n_samples_d;
            n_errors_q  <= n_errors_d;
            bad_a_q     <= bad_a_d;
            bad_y_q     <= bad_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end
endmodule

// File: tb/tb_chk_gnot16.sv
// Bench for chk_gnot16: behavioural model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_chk_gnot16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    chk_gnot16_if #(.WIDTH(16), .CNT_W(8)) bus ();

    chk_gnot16 #(.WIDTH(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a run is "active" or "finished"; counts are plain ints.
    bit         m_active = 1'b0;
    bit         m_finished = 1'b0;
    int         m_len = 0;
    int         m_ns = 0;
    int         m_ne = 0;
    logic [15:0] m_ba = '0;
    logic [15:0] m_by = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_finished = 1'b0; m_len = 0;
            m_ns = 0; m_ne = 0; m_ba = '0; m_by = '0;
        end else if (!m_active && bus.start) begin
            m_len = int'(bus.len);
            m_ns = 0; m_ne = 0; m_ba = '0; m_by = '0;
            m_active   = (m_len != 0);
            m_finished = (m_len == 0);
        end else if (m_active && bus.valid) begin
            m_ns = m_ns + 1;
            if ((bus.a ^ bus.y) != 16'hFFFF) begin
                if (m_ne == 0) begin
                    m_ba = bus.a;
                    m_by = bus.y;
                end
                m_ne = (m_ne < 255) ? m_ne + 1 : 255;
`ifdef CHK_GNOT16_ABORT_EN
                if (m_ne == 1) begin
                    m_active = 1'b0; m_finished = 1'b1;
                end
`endif
            end
            if (m_ns == m_len) begin
                m_active = 1'b0; m_finished = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        chk("busy",      32'(bus.busy),      32'(m_active));
        chk("done",      32'(bus.done),      32'(m_finished));
        chk("pass",      32'(bus.pass),      32'(m_finished && m_ne == 0));
        chk("n_samples", 32'(bus.n_samples), 32'(m_ns));
        chk("n_errors",  32'(bus.n_errors),  32'(m_ne));
        chk("bad_a",     32'(bus.bad_a),     32'(m_ba));
        chk("bad_y",     32'(bus.bad_y),     32'(m_by));
    end

    task automatic drive(input logic r, input logic s, input logic [7:0] l,
                         input logic v, input logic [15:0] aa, input logic [15:0] yy);
        @(negedge clk);
        rst = r; bus.start = s; bus.len = l; bus.valid = v; bus.a = aa; bus.y = yy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic pair(input logic [15:0] aa, input logic [15:0] yy);
        drive(1'b0, 1'b0, 8'd99, 1'b1, aa, yy);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.valid = 1'b0; bus.a = '0; bus.y = '0;
        drive(1'b1, 1'b0, 8'd0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 16'h0, 16'h0);
        idle(5);
        chk("lit_reset_busy", 32'(bus.busy), 32'd0);
        chk("lit_reset_done", 32'(bus.done), 32'd0);
        chk("lit_reset_ns",   32'(bus.n_samples), 32'd0);

        // All-correct run of 4; start together with valid (valid ignored).
        drive(1'b0, 1'b1, 8'd4, 1'b1, 16'h0000, 16'h0000);
        pair(16'h0000, 16'hFFFF);
        pair(16'h0001, 16'hFFFE);
        pair(16'hA5A5, 16'h5A5A);
        pair(16'hFFFF, 16'h0000);
        idle(1);
        chk("lit_t2_done", 32'(bus.done), 32'd1);
        chk("lit_t2_pass", 32'(bus.pass), 32'd1);
        chk("lit_t2_ns",   32'(bus.n_samples), 32'd4);
        chk("lit_t2_ne",   32'(bus.n_errors), 32'd0);
        idle(2);

        // Two mismatches in a run of 3.
        drive(1'b0, 1'b1, 8'd3, 1'b0, 16'h0, 16'h0);
        pair(16'h0001, 16'hFFFE);
        pair(16'h1234, 16'h1234);
        pair(16'h00FF, 16'h0000);
        idle(1);
        chk("lit_t3_bad_a", 32'(bus.bad_a), 32'h1234);
        chk("lit_t3_bad_y", 32'(bus.bad_y), 32'h1234);
        chk("lit_t3_pass",  32'(bus.pass), 32'd0);
        chk("lit_t3_done",  32'(bus.done), 32'd1);
`ifdef CHK_GNOT16_ABORT_EN
        chk("lit_t3_ns", 32'(bus.n_samples), 32'd2);
        chk("lit_t3_ne", 32'(bus.n_errors), 32'd1);
`else
        chk("lit_t3_ns", 32'(bus.n_samples), 32'd3);
        chk("lit_t3_ne", 32'(bus.n_errors), 32'd2);
`endif
        idle(2);

        // Gaps of 2 cycles and a start pulse mid-run.
        drive(1'b0, 1'b1, 8'd3, 1'b0, 16'h0, 16'h0);
        pair(16'h1111, 16'hEEEE);
        idle(2);
        drive(1'b0, 1'b1, 8'd7, 1'b0, 16'h0, 16'h0);
        idle(1);
        pair(16'h2222, 16'hDDDD);
        idle(2);
        chk("lit_t4_busy", 32'(bus.busy), 32'd1);
        chk("lit_t4_ns",   32'(bus.n_samples), 32'd2);
        pair(16'h3333, 16'hCCCC);
        idle(1);
        chk("lit_t4_done", 32'(bus.done), 32'd1);
        chk("lit_t4_ns3",  32'(bus.n_samples), 32'd3);
        idle(2);

        // len = 0 completes immediately.
        drive(1'b0, 1'b1, 8'd0, 1'b0, 16'h0, 16'h0);
        idle(1);
        chk("lit_t5_done", 32'(bus.done), 32'd1);
        chk("lit_t5_pass", 32'(bus.pass), 32'd1);
        chk("lit_t5_ns",   32'(bus.n_samples), 32'd0);

        // Reset mid-run, then a run of 1 (mismatch).
        drive(1'b0, 1'b1, 8'd4, 1'b0, 16'h0, 16'h0);
        pair(16'h0F0F, 16'h0F0F);
        pair(16'h4444, 16'hBBBB);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 16'h5555, 16'h5555);
        idle(1);
        chk("lit_t6_busy",  32'(bus.busy), 32'd0);
        chk("lit_t6_ne",    32'(bus.n_errors), 32'd0);
        chk("lit_t6_bad_a", 32'(bus.bad_a), 32'd0);
        drive(1'b0, 1'b1, 8'd1, 1'b0, 16'h0, 16'h0);
        pair(16'h8001, 16'h7FFF);
        idle(1);
        chk("lit_t6_done",  32'(bus.done), 32'd1);
        chk("lit_t6_bad_y", 32'(bus.bad_y), 32'h7FFF);

        // Maximum length run: no counter wrap.
        drive(1'b0, 1'b1, 8'd255, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 255; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            pair(ra, ($urandom_range(0, 9) == 0) ? 16'($urandom) : ~ra);
        end
        idle(1);
        chk("lit_max_done", 32'(bus.done), 32'd1);
`ifndef CHK_GNOT16_ABORT_EN
        chk("lit_max_ns", 32'(bus.n_samples), 32'd255);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 19) == 0,
                  8'($urandom_range(0, 6)),
                  $urandom_range(0, 9) < 7,
                  ra,
                  ($urandom_range(0, 4) == 0) ? (~ra ^ (16'd1 << $urandom_range(0, 15))) : ~ra);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
